// File: rtl/slow_clk_meter_pkg.sv
// Shared FSM encoding, default timing constants and the period range check.
// Latency: n/a (types/functions only). Backpressure: n/a.
// Used by slow_clk_period_meter; no state lives here.
package slow_clk_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } meter_state_t;

    localparam int unsigned DEF_EXPECTED_PERIOD = 1000000;
    localparam int unsigned DEF_TOLERANCE       = 1000;
    localparam int unsigned DEF_TIMEOUT         = 1500000;

    // Inclusive window; written as val+tol >= expected so it never underflows.
    function automatic logic period_in_range(input int unsigned val,
                                             input int unsigned expected,
                                             input int unsigned tol);
        return ((val + tol) >= expected) && (val <= (expected + tol));
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level and emits a registered 1-cycle pulse per rising edge.
// Latency: STAGES+1 in_clk cycles from input rise to pulse (+/-1 for metastability).
// Backpressure: none; clear only drops the output pulse, the sync chain keeps tracking the input.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic in_clk,
    input  logic rst_n,
    input  logic clear,
    input  logic din,
    output logic rise_pulse
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            hist_q     <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[STAGES-2:0], din};
            hist_q     <= sync_q[STAGES-1];
            // Keeping the chain alive through clear avoids a false edge when din is already high.
            rise_pulse <= clear ? 1'b0 : (sync_q[STAGES-1] & ~hist_q);
        end
    end

endmodule

// File: rtl/slow_clk_period_meter.sv
// Measures slow_clk periods in in_clk cycles, tracks lock and loss of clock; SLOW_CLK_PERIOD_AVG_EN adds a 4-sample average.
// Latency: period/period_valid/locked one cycle after rise_pulse; timeout TIMEOUT cycles after the last rise_pulse.
// Backpressure: none; free-running monitor, outputs are registered status consumed at will.
module slow_clk_period_meter
    import slow_clk_meter_pkg::*;
#(
    parameter int          SYNC_STAGES     = 2,
    parameter int          CNT_W           = 21,
    parameter int unsigned EXPECTED_PERIOD = DEF_EXPECTED_PERIOD,
    parameter int unsigned TOLERANCE       = DEF_TOLERANCE,
    parameter int unsigned TIMEOUT         = DEF_TIMEOUT,
    parameter int unsigned LOCK_COUNT      = 4
) (
    input  logic             in_clk,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic             clear,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] period_avg,
    output logic             locked,
    output logic             timeout
);

    localparam int LK_W = $clog2(LOCK_COUNT + 1);

    meter_state_t     state_q, state_d;
    logic [LK_W-1:0]  lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q;
    logic             rise, to_hit, in_rng, upd, locked_d, timeout_d;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
        .in_clk     (in_clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .din        (slow_clk),
        .rise_pulse (rise_pulse)
    );

    assign rise   = rise_pulse & ~clear;
    // Fires on the cycle the counter would step onto TIMEOUT; a rise that cycle pre-empts it.
    assign to_hit = ~rise && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign in_rng = period_in_range(32'(cnt_q), EXPECTED_PERIOD, TOLERANCE);

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (rise) begin
            cnt_q <= CNT_W'(1);
        end else if (cnt_q != CNT_W'(TIMEOUT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        locked_d  = locked;
        timeout_d = timeout;
        upd       = 1'b0;
        if (to_hit) begin
            state_d   = ST_IDLE;
            lock_d    = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
        end else if (rise) begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_MEASURE;
                    lock_d    = '0;
                    timeout_d = 1'b0;
                end
                ST_MEASURE: begin
                    upd = 1'b1;
                    if (!in_rng) begin
                        lock_d = '0;
                    end else if (lock_q == LK_W'(LOCK_COUNT - 1)) begin
                        state_d  = ST_LOCKED;
                        lock_d   = LK_W'(LOCK_COUNT);
                        locked_d = 1'b1;
                    end else begin
                        lock_d = lock_q + LK_W'(1);
                    end
                end
                ST_LOCKED: begin
                    upd = 1'b1;
                    if (!in_rng) begin
                        state_d  = ST_MEASURE;
                        lock_d   = '0;
                        locked_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (clear) begin
            state_d   = ST_IDLE;
            lock_d    = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
            upd       = 1'b0;
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lock_q       <= '0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            period_valid <= 1'b0;
            period       <= '0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            locked       <= locked_d;
            timeout      <= timeout_d;
            period_valid <= upd;
            if (clear) begin
                period <= '0;
            end else if (upd) begin
                period <= cnt_q;
            end
        end
    end

`ifdef SLOW_CLK_PERIOD_AVG_EN
    localparam int SUM_W = CNT_W + 2;

    logic [CNT_W-1:0] avg_h0_q, avg_h1_q, avg_h2_q;
    logic [1:0]       avg_fill_q;
    logic [SUM_W-1:0] avg_sum;
    logic             avg_flush;

    assign avg_flush = clear || ((state_d == ST_IDLE) && (state_q != ST_IDLE));
    assign avg_sum   = SUM_W'(cnt_q) + SUM_W'(avg_h0_q) + SUM_W'(avg_h1_q) + SUM_W'(avg_h2_q);

    // The incoming period plus three held samples form the 4-deep window.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_h0_q   <= '0;
            avg_h1_q   <= '0;
            avg_h2_q   <= '0;
            avg_fill_q <= '0;
            period_avg <= '0;
        end else if (avg_flush) begin
            avg_h0_q   <= '0;
            avg_h1_q   <= '0;
            avg_h2_q   <= '0;
            avg_fill_q <= '0;
            period_avg <= '0;
        end else if (upd) begin
            avg_h0_q   <= cnt_q;
            avg_h1_q   <= avg_h0_q;
            avg_h2_q   <= avg_h1_q;
            if (avg_fill_q != 2'd3) begin
                avg_fill_q <= avg_fill_q + 2'd1;
            end
            period_avg <= (avg_fill_q == 2'd3) ? avg_sum[SUM_W-1:2] : '0;
        end
    end
`else
    assign period_avg = period;
`endif

endmodule
